// File: rtl/ps2_pkg.sv
// Shared constants, types and the frame-check helper for the PS/2 receive path.
package ps2_pkg;

  // Start + 8 data + parity + stop.
  localparam int FRAME_BITS = 11;

  // Prefix bytes; they are buffered like any other scancode.
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int CNT_W = $clog2(FRAME_BITS);
  typedef logic [CNT_W-1:0] bit_cnt_t;

  // Counter value at which the stop bit is sampled.
  localparam bit_cnt_t LAST_BIT = bit_cnt_t'(FRAME_BITS - 1);

  // Validates a frame: bits[0]=start, bits[8:1]=data, bits[9]=parity;
  // the stop bit arrives live on the final falling edge.
  function automatic logic frame_ok(input logic [9:0] bits, input logic stop);
    return (bits[0] == 1'b0) && (stop == 1'b1) && (^bits[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous scancode FIFO with a registered head byte.
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [AW:0] wptr_nxt, rptr_nxt;
  logic        do_push, do_pop;
  logic [7:0]  head_q, head_nxt;

  // Status flags and guarded handshakes; a pop frees a slot for a push in the same cycle.
  always_comb begin
    empty    = (wptr == rptr);
    full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wptr_nxt = wptr + (AW+1)'(do_push);
    rptr_nxt = rptr + (AW+1)'(do_pop);
  end

  // Next head byte: the incoming byte when it becomes the head, otherwise the stored entry.
  always_comb begin
    // NOTE: default assignment first so no path leaves head_nxt unassigned (no latch).
    head_nxt = head_q;
    if (wptr_nxt != rptr_nxt) begin
      if (wptr == rptr_nxt) head_nxt = din;
      else                  head_nxt = mem[rptr_nxt[AW-1:0]];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; pointers alone define which entries are valid.
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  // Pointer and head register update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: non-blocking assignments for all sequential state so every flop sees pre-edge values.
      wptr   <= '0;
      rptr   <= '0;
      head_q <= 8'h00;
    end else begin
      wptr   <= wptr_nxt;
      rptr   <= rptr_nxt;
      head_q <= head_nxt;
    end
  end

  assign head = head_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pad synchroniser, 11-bit frame deserialiser with
// timeout resync, frame check, scancode FIFO and last-popped scancode register.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic [7:0] scancode,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]        clk_sync;
  logic [1:0]        data_sync;
  logic              fall;
  logic              data_s;
  bit_cnt_t          cnt;
  logic [9:0]        shift_buf;
  logic [TCNT_W-1:0] tcnt;
  logic              frame_done;
  logic              frame_good;
  logic              timeout;
  logic              pop_now;
  logic              room;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;

  // Pad synchronisers; idle level of the bus is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall   = clk_sync[2] && !clk_sync[1];
  assign data_s = data_sync[1];

  // Frame-level decode and FIFO handshake.
  always_comb begin
    frame_done = fall && (cnt == LAST_BIT);
    frame_good = frame_ok(shift_buf, data_s);
    timeout    = (cnt != '0) && (tcnt == TCNT_MAX);
    pop_now    = !nextdata_n && ready;
    room       = !fifo_full || pop_now;
    push       = frame_done && frame_good && room;
  end

  // Bit counter and shift buffer; a stalled partial frame is abandoned on timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      shift_buf <= '0;
    end else if (fall) begin
      if (cnt == LAST_BIT) begin
        cnt <= '0;
      end else begin
        shift_buf[cnt] <= data_s;
        cnt            <= cnt + 1'b1;
      end
    end else if (timeout) begin
      cnt <= '0;
    end
  end

  // Inactivity counter: runs only mid-frame, restarts on every falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            tcnt <= '0;
    else if (cnt == '0 || fall || timeout)  tcnt <= '0;
    else                                    tcnt <= tcnt + 1'b1;
  end

  // Status outputs: sticky overflow cleared by a pop, one-cycle frame error pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_done && !frame_good;
      if (pop_now)                                overflow <= 1'b0;
      else if (frame_done && frame_good && !room) overflow <= 1'b1;
    end
  end

  // Last popped byte, held for the ASCII stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      scancode <= 8'h00;
    else if (pop_now) scancode <= data;
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop_now),
    .din    (shift_buf[8:1]),
    .head   (data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign ready = !fifo_empty;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: frames, parity error, overflow, timeout,
// break codes, held pop and mid-frame reset.
module tb_ps2_scan_rx;
  import ps2_pkg::*;

  localparam int HALF    = 20;   // ps2_clk half period in clk cycles
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic [7:0] scancode;
  logic       overflow;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  int err_pulses = 0;
  int err_mark;

  always #10 clk = ~clk;  // 50 MHz

  ps2_scan_rx #(
    .FIFO_DEPTH  (8),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .scancode   (scancode),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  // One count per clk cycle that frame_err is high.
  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the first nbits bits of a frame and returns right after the last falling edge.
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    ps2_data = f[0];
    wait_neg(HALF);
    for (int i = 0; i < nbits; i++) begin
      ps2_clk = 1'b0;
      if (i == nbits - 1) break;
      wait_neg(HALF / 2);
      ps2_data = f[i+1];
      wait_neg(HALF / 2);
      ps2_clk = 1'b1;
      wait_neg(HALF);
    end
  endtask

  // Completes the low phase after send_bits and returns the bus to idle.
  task automatic finish_frame();
    wait_neg(HALF / 2);
    ps2_data = 1'b1;
    wait_neg(HALF / 2);
    ps2_clk = 1'b1;
    wait_neg(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bits(b, bad_par, FRAME_BITS);
    finish_frame();
  endtask

  task automatic pop();
    @(negedge clk) nextdata_n = 1'b0;
    @(negedge clk) nextdata_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp;
    resetn     = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    wait_neg(5);
    check("rst data",      data,      8'h00);
    check("rst ready",     ready,     1'b0);
    check("rst scancode",  scancode,  8'h00);
    check("rst overflow",  overflow,  1'b0);
    check("rst frame_err", frame_err, 1'b0);
    resetn = 1'b1;
    wait_neg(5);

    // 1: single frame, latency from the last pad fall, then pop
    send_bits(8'h1C, 1'b0, FRAME_BITS);
    repeat (2) @(posedge clk);
    #1 check("t1 ready at +2", ready, 1'b0);
    @(posedge clk);
    #1 check("t1 ready at +3", ready, 1'b1);
    check("t1 data", data, 8'h1C);
    finish_frame();
    pop();
    check("t1 ready after pop", ready, 1'b0);
    check("t1 scancode", scancode, 8'h1C);

    // 2: bad parity
    err_mark = err_pulses;
    send_frame(8'h1C, 1'b1);
    check("t2 err cycles", 8'(err_pulses - err_mark), 8'd1);
    check("t2 ready", ready, 1'b0);
    check("t2 scancode", scancode, 8'h1C);

    // 3: overflow on the ninth frame, then drain in order
    for (int k = 0; k < 9; k++) send_frame(8'h16 + 8'(6 * k), 1'b0);
    check("t3 overflow", overflow, 1'b1);
    check("t3 ready", ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      exp = 8'h16 + 8'(6 * k);
      check($sformatf("t3 head %0d", k), data, exp);
      pop();
      check($sformatf("t3 scancode %0d", k), scancode, exp);
      check($sformatf("t3 overflow %0d", k), overflow, 1'b0);
    end
    check("t3 drained", ready, 1'b0);

    // 4: partial frame abandoned by timeout, then a clean frame
    err_mark = err_pulses;
    send_bits(8'h77, 1'b0, 4);
    finish_frame();
    wait_neg(TIMEOUT + 60);
    send_frame(8'h45, 1'b0);
    check("t4 ready", ready, 1'b1);
    check("t4 data", data, 8'h45);
    check("t4 no err", 8'(err_pulses - err_mark), 8'd0);
    pop();
    check("t4 scancode", scancode, 8'h45);

    // 5: break prefix then code; pop held low across both and one empty cycle
    send_frame(PS2_BREAK, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("t5 head", data, PS2_BREAK);
    @(negedge clk) nextdata_n = 1'b0;
    @(negedge clk) check("t5 pop1", scancode, PS2_BREAK);
    check("t5 ready after pop1", ready, 1'b1);
    @(negedge clk) check("t5 pop2", scancode, 8'h1C);
    check("t5 empty", ready, 1'b0);
    @(negedge clk) check("t5 empty pop scancode", scancode, 8'h1C);
    check("t5 empty pop overflow", overflow, 1'b0);
    nextdata_n = 1'b1;
    wait_neg(3);
    check("t5 still empty", ready, 1'b0);

    // 6: reset in the middle of a frame with a byte already queued
    send_frame(8'h5A, 1'b0);
    check("t6 queued", ready, 1'b1);
    send_bits(8'h33, 1'b0, 6);
    wait_neg(HALF / 2);
    resetn = 1'b0;
    #1;
    check("t6 rst data",      data,      8'h00);
    check("t6 rst ready",     ready,     1'b0);
    check("t6 rst scancode",  scancode,  8'h00);
    check("t6 rst overflow",  overflow,  1'b0);
    check("t6 rst frame_err", frame_err, 1'b0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_neg(5);
    resetn = 1'b1;
    wait_neg(HALF);
    err_mark = err_pulses;
    send_frame(8'h2B, 1'b0);
    check("t6 ready", ready, 1'b1);
    check("t6 data", data, 8'h2B);
    check("t6 no err", 8'(err_pulses - err_mark), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
